cpu_datapath: RTL and testbench
===============================

// Module: cpu_datapath
// PURPOSE
//  8-bit multicycle CPU datapath driven cycle-by-cycle by the FSM controller's control word.
//  Holds PC, IR, MDR, a 4x8 register file, the A/B operand latches, the ALU, ALUout and the N/Z flags.
//  Produces the controller's status inputs (OpCode, N, Z, Aout, Bout, ALUregOut).
//  Drives the address and write data of the external single-port memory.
// PARAMETERS
//  WIDTH  8  data/address width (the ISA is fixed at 8; other values are unsupported)
// PORTS
//  CLOCK_50   in   1  system clock, all state updates on rising edge
//  reset      in   1  asynchronous, active-high; clears all state
//  PCwrite    in   1  PC <= ALU result
//  AddrSel    in   1  1: MemAddr=PC, 0: MemAddr=B
//  IRload     in   1  IR <= MemRData
//  MDRload    in   1  MDR <= MemRData
//  RASel      in   1  read-address-A select: 0 = IR[7:6], 1 = 2'b01
//  RFWrite    in   1  RF[RA] <= write data
//  RegIn      in   1  write data: 0 = ALUout, 1 = MDR
//  ABLD       in   1  A <= RF[raddrA], B <= RF[IR[5:4]]
//  ALU_A      in   1  ALU operand X: 0 = PC, 1 = A
//  ALU_B      in   3  ALU operand Y select (see BEHAVIOUR)
//  ALUop      in   3  ALU function (see BEHAVIOUR)
//  FlagWrite  in   1  N,Z <= flags of the ALU result
//  ALUoutLD   in   1  ALUout <= ALU result
//  MemRData   in   8  memory read data (combinational from MemAddr)
//  MemAddr    out  8  memory address (combinational)
//  MemWData   out  8  memory write data = A
//  OpCode     out  8  IR contents
//  Aout, Bout out  8  A/B latch contents
//  ALUregOut  out  8  ALUout register
//  N, Z       out  1  flag registers
//  PCout      out  8  PC contents (HEX display / debug)
// BEHAVIOUR
//  - Reset values: PC, IR, MDR, A, B, ALUout, RA, RF[0..3] = 0x00; N = 0; Z = 0.
//    Reset is asynchronous and overrides any control input.
//  - ALU_B select: 000 = B; 001 = 0x01; 010 = SE(IR[7:4]); 011 = ZE(IR[7:3]); 100 = ZE(IR[4:3]);
//    101..111 = 0x00.
//  - ALUop: 000 = X+Y; 001 = X-Y; 010 = X|Y; 011 = ~(X&Y); 100 = X<<Y[2:0]; 101 = X>>Y[2:0] (logical);
//    110/111 = 0x00.
//  - All arithmetic is modulo 256 with no carry/overflow output. PC wraps from 0xFF to 0x00.
//  - ALU result and flag values are purely combinational from the current registers and controls.
//    N = result[7]; Z = (result == 0).
//  - Operand/address latch: A and RA load when ABLD=1 or RASel=1.
//    RA <= (RASel ? 2'b01 : IR[7:6]); A <= RF[that address].
//  - B loads only when ABLD=1.
//  - RF writes always target the latched RA, never the live RASel mux.
//  - RF has 2 combinational read ports and 1 synchronous write port. A read in the same cycle as a write
//    returns the pre-write value (no bypass).
//  - Every register loads only on its enable and holds otherwise. Enables are independent, so any
//    combination in one cycle is legal.
//  - PCwrite with IRload (fetch): the IR is captured from MemAddr=PC(old), and PC becomes
//    ALU(PC, Y) in the same edge.
//  - Latency: fetch = 1 edge; status outputs (OpCode, N, Z, A/B, ALUout) are valid the cycle after
//    their load enable.
//  - MemRead and MemWrite are not ports of this block; they go straight from the controller to memory.
//    MemWData is always A.
// TESTING
//  - Reset mid-run: load R1=0x33, PC=0x20, then pulse reset between edges -> all outputs 0x00/0
//    immediately (asynchronously).
//  - Fetch: PC=0x05, MemRData=0x46, with AddrSel=1, IRload=1, PCwrite=1, ALU_A=0, ALU_B=001:
//    MemAddr=0x05 -> OpCode=0x46, PC=0x06.
//  - ADD: R1=0x7F, R2=0x01, IR=0x64, ABLD, then ALUop=000, ALU_B=000, ALU_A=1, ALUoutLD, FlagWrite,
//    then RFWrite, RegIn=0 -> ALUregOut=0x80, N=1, Z=0, R1=0x80.
//  - SUB equal operands: 0x5A-0x5A -> 0x00, Z=1, N=0.
//  - Branch: PC=0x10, IR[7:4]=0xE, ALU_B=010, PCwrite -> PC=0x0E.
//    PC=0xFF with the +1 fetch -> PC=0x00.
//  - ORi: R1=0x40, IR=0xAF. Sequence: RASel=1; then ALU_B=011, ALUop=010, ALUoutLD; then RFWrite
//    -> R1=0x55, RA=1, other registers unchanged.
//  - Shift: R0=0x81, IR[4:3]=2, ALUop=100 -> 0x04.
//    ALUop=101 with IR[4:3]=3 -> 0x10, N=0, Z=0.
//  - LOAD: B=0x30, AddrSel=0, MemRData=0x9C, MDRload; then RegIn=1, RFWrite
//    -> MemAddr=0x30, RF[RA]=0x9C.

Source files
------------

// File: rtl/cpu_datapath.sv
// 8-bit multicycle CPU datapath: PC, IR, MDR, 4x8 register file, A/B latches, ALU, ALUout, N/Z.
// Every register is steered by one bit of the controller's control word and holds otherwise.
module cpu_datapath #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             PCwrite,
  input  logic             AddrSel,
  input  logic             IRload,
  input  logic             MDRload,
  input  logic             RASel,
  input  logic             RFWrite,
  input  logic             RegIn,
  input  logic             ABLD,
  input  logic             ALU_A,
  input  logic [2:0]       ALU_B,
  input  logic [2:0]       ALUop,
  input  logic             FlagWrite,
  input  logic             ALUoutLD,
  input  logic [WIDTH-1:0] MemRData,
  output logic [WIDTH-1:0] MemAddr,
  output logic [WIDTH-1:0] MemWData,
  output logic [WIDTH-1:0] OpCode,
  output logic [WIDTH-1:0] Aout,
  output logic [WIDTH-1:0] Bout,
  output logic [WIDTH-1:0] ALUregOut,
  output logic             N,
  output logic             Z,
  output logic [WIDTH-1:0] PCout
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic [WIDTH-1:0] mdr_q, mdr_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] aluout_q, aluout_d;
  logic [1:0]       ra_q, ra_d;
  logic             n_q, n_d;
  logic             z_q, z_d;
  logic [WIDTH-1:0] rf_q [4];
  logic [WIDTH-1:0] rf_d [4];

  logic [1:0]       raddr_a;
  logic [WIDTH-1:0] alu_x, alu_y, alu_res, rf_wdata;

  assign raddr_a  = RASel ? 2'b01 : ir_q[7:6];
  assign rf_wdata = RegIn ? mdr_q : aluout_q;

  always_comb begin
    alu_x = ALU_A ? a_q : pc_q;
    alu_y = '0;
    case (ALU_B)
      3'b000:  alu_y = b_q;
      3'b001:  alu_y = WIDTH'(1);
      3'b010:  alu_y = {{(WIDTH-4){ir_q[7]}}, ir_q[7:4]};
      3'b011:  alu_y = {{(WIDTH-5){1'b0}}, ir_q[7:3]};
      3'b100:  alu_y = {{(WIDTH-2){1'b0}}, ir_q[4:3]};
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (ALUop)
      3'b000:  alu_res = alu_x + alu_y;
      3'b001:  alu_res = alu_x - alu_y;
      3'b010:  alu_res = alu_x | alu_y;
      3'b011:  alu_res = ~(alu_x & alu_y);
      3'b100:  alu_res = alu_x << alu_y[2:0];
      3'b101:  alu_res = alu_x >> alu_y[2:0];
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    mdr_d    = mdr_q;
    a_d      = a_q;
    b_d      = b_q;
    aluout_d = aluout_q;
    ra_d     = ra_q;
    n_d      = n_q;
    z_d      = z_q;
    for (int i = 0; i < 4; i++) rf_d[i] = rf_q[i];

    if (PCwrite)  pc_d  = alu_res;
    if (IRload)   ir_d  = MemRData;
    if (MDRload)  mdr_d = MemRData;
    // A and RA track together so a later RF write lands where A was read from.
    if (ABLD || RASel) begin
      ra_d = raddr_a;
      a_d  = rf_q[raddr_a];
    end
    if (ABLD)     b_d      = rf_q[ir_q[5:4]];
    if (ALUoutLD) aluout_d = alu_res;
    if (FlagWrite) begin
      n_d = alu_res[WIDTH-1];
      z_d = (alu_res == '0);
    end
    if (RFWrite)  rf_d[ra_q] = rf_wdata;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      pc_q     <= '0;
      ir_q     <= '0;
      mdr_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      ra_q     <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      for (int i = 0; i < 4; i++) rf_q[i] <= '0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      mdr_q    <= mdr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
      ra_q     <= ra_d;
      n_q      <= n_d;
      z_q      <= z_d;
      for (int i = 0; i < 4; i++) rf_q[i] <= rf_d[i];
    end
  end

  assign MemAddr   = AddrSel ? pc_q : b_q;
  assign MemWData  = a_q;
  assign OpCode    = ir_q;
  assign Aout      = a_q;
  assign Bout      = b_q;
  assign ALUregOut = aluout_q;
  assign N         = n_q;
  assign Z         = z_q;
  assign PCout     = pc_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath: ALU vector table plus hand sequences for fetch, branch,
// ORi, LOAD, read-during-write and asynchronous reset.
module tb_cpu_datapath;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       PCwrite, AddrSel, IRload, MDRload, RASel, RFWrite, RegIn, ABLD, ALU_A;
  logic [2:0] ALU_B, ALUop;
  logic       FlagWrite, ALUoutLD;
  logic [7:0] MemRData;
  logic [7:0] MemAddr, MemWData, OpCode, Aout, Bout, ALUregOut, PCout;
  logic       N, Z;

  int checks   = 0;
  int failures = 0;

  cpu_datapath #(.WIDTH(8)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .PCwrite   (PCwrite),
    .AddrSel   (AddrSel),
    .IRload    (IRload),
    .MDRload   (MDRload),
    .RASel     (RASel),
    .RFWrite   (RFWrite),
    .RegIn     (RegIn),
    .ABLD      (ABLD),
    .ALU_A     (ALU_A),
    .ALU_B     (ALU_B),
    .ALUop     (ALUop),
    .FlagWrite (FlagWrite),
    .ALUoutLD  (ALUoutLD),
    .MemRData  (MemRData),
    .MemAddr   (MemAddr),
    .MemWData  (MemWData),
    .OpCode    (OpCode),
    .Aout      (Aout),
    .Bout      (Bout),
    .ALUregOut (ALUregOut),
    .N         (N),
    .Z         (Z),
    .PCout     (PCout)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] ir;
    logic [2:0] sel;
    logic [2:0] op;
    logic [7:0] res;
    logic       n;
    logic       z;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic clr();
    PCwrite = 0; AddrSel = 0; IRload = 0; MDRload = 0; RASel = 0; RFWrite = 0;
    RegIn = 0; ABLD = 0; ALU_A = 0; ALU_B = 3'b000; ALUop = 3'b000; FlagWrite = 0;
    ALUoutLD = 0;
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic load_ir(input logic [7:0] v);
    clr(); AddrSel = 1; MemRData = v; IRload = 1; tick(); clr();
  endtask

  task automatic load_ab(input logic [1:0] ra, input logic [1:0] rb);
    load_ir({ra, rb, 4'h0});
    ABLD = 1; tick(); clr();
  endtask

  task automatic write_rf(input logic [1:0] r, input logic [7:0] v);
    load_ab(r, r);
    MemRData = v; MDRload = 1; tick(); clr();
    RegIn = 1; RFWrite = 1; tick(); clr();
  endtask

  task automatic read_rf(input logic [1:0] r, output logic [7:0] v);
    load_ab(r, r);
    v = Aout;
  endtask

  task automatic set_pc(input logic [7:0] v);
    write_rf(2'd0, v);
    load_ab(2'd0, 2'd0);
    ALU_A = 1; ALU_B = 3'b101; ALUop = 3'b000; PCwrite = 1; tick(); clr();
  endtask

  logic [7:0] rd;

  initial begin
    //              a      b      ir     sel     op      res    n  z
    vecs[0]  = '{8'h7F, 8'h01, 8'h10, 3'b000, 3'b000, 8'h80, 1, 0};
    vecs[1]  = '{8'h5A, 8'h5A, 8'h10, 3'b000, 3'b001, 8'h00, 0, 1};
    vecs[2]  = '{8'h40, 8'h00, 8'hAF, 3'b011, 3'b010, 8'h55, 0, 0};
    vecs[3]  = '{8'hF0, 8'hFF, 8'h10, 3'b000, 3'b011, 8'h0F, 0, 0};
    vecs[4]  = '{8'h81, 8'h00, 8'h10, 3'b100, 3'b100, 8'h04, 0, 0};
    vecs[5]  = '{8'h81, 8'h00, 8'h18, 3'b100, 3'b101, 8'h10, 0, 0};
    vecs[6]  = '{8'h12, 8'h34, 8'h10, 3'b000, 3'b110, 8'h00, 0, 1};
    vecs[7]  = '{8'hFF, 8'h00, 8'h10, 3'b001, 3'b000, 8'h00, 0, 1};
    vecs[8]  = '{8'h10, 8'h00, 8'hE0, 3'b010, 3'b000, 8'h0E, 0, 0};
    vecs[9]  = '{8'h10, 8'h00, 8'h70, 3'b010, 3'b000, 8'h17, 0, 0};
    vecs[10] = '{8'h33, 8'h44, 8'h10, 3'b101, 3'b000, 8'h33, 0, 0};
    vecs[11] = '{8'h00, 8'h01, 8'h10, 3'b000, 3'b001, 8'hFF, 1, 0};
    vecs[12] = '{8'h01, 8'h0B, 8'h10, 3'b000, 3'b100, 8'h08, 0, 0};
    vecs[13] = '{8'h80, 8'hF7, 8'h10, 3'b000, 3'b101, 8'h01, 0, 0};

    clr();
    MemRData = 8'h00;
    reset = 1;
    #3;
    chk("rst_pc", PCout, 8'h00);
    chk("rst_ir", OpCode, 8'h00);
    chk("rst_alu", ALUregOut, 8'h00);
    chk("rst_nz", {6'b0, N, Z}, 8'h00);
    @(negedge CLOCK_50);
    reset = 0;
    #1;

    // ALU table: R0 -> A, R1 -> B, then IR supplies immediates.
    for (int i = 0; i < 14; i++) begin
      write_rf(2'd0, vecs[i].a);
      write_rf(2'd1, vecs[i].b);
      load_ab(2'd0, 2'd1);
      load_ir(vecs[i].ir);
      ALU_A = 1; ALU_B = vecs[i].sel; ALUop = vecs[i].op; ALUoutLD = 1; FlagWrite = 1;
      tick(); clr();
      chk($sformatf("vec%0d_res", i), ALUregOut, vecs[i].res);
      chk($sformatf("vec%0d_nz", i), {6'b0, N, Z}, {6'b0, vecs[i].n, vecs[i].z});
    end

    // Fetch: IR from MemAddr=old PC, PC increments on the same edge.
    set_pc(8'h05);
    AddrSel = 1; MemRData = 8'h46; IRload = 1; PCwrite = 1; ALU_A = 0; ALU_B = 3'b001;
    #1;
    chk("fetch_addr", MemAddr, 8'h05);
    tick(); clr();
    chk("fetch_ir", OpCode, 8'h46);
    chk("fetch_pc", PCout, 8'h06);

    set_pc(8'hFF);
    AddrSel = 1; MemRData = 8'h00; IRload = 1; PCwrite = 1; ALU_A = 0; ALU_B = 3'b001;
    tick(); clr();
    chk("pc_wrap", PCout, 8'h00);

    set_pc(8'h10);
    load_ir(8'hE0);
    ALU_A = 0; ALU_B = 3'b010; ALUop = 3'b000; PCwrite = 1; tick(); clr();
    chk("branch_pc", PCout, 8'h0E);

    // ORi: RASel forces RA=1 even though IR[7:6]=2.
    write_rf(2'd0, 8'h11);
    write_rf(2'd2, 8'h22);
    write_rf(2'd3, 8'h33);
    write_rf(2'd1, 8'h40);
    load_ir(8'hAF);
    RASel = 1; tick(); clr();
    chk("ori_a", Aout, 8'h40);
    ALU_A = 1; ALU_B = 3'b011; ALUop = 3'b010; ALUoutLD = 1; tick(); clr();
    chk("ori_aluout", ALUregOut, 8'h55);
    RFWrite = 1; RegIn = 0; tick(); clr();
    read_rf(2'd1, rd); chk("ori_r1", rd, 8'h55);
    read_rf(2'd0, rd); chk("ori_r0", rd, 8'h11);
    read_rf(2'd2, rd); chk("ori_r2", rd, 8'h22);
    read_rf(2'd3, rd); chk("ori_r3", rd, 8'h33);

    // LOAD through MDR, addressed by B.
    write_rf(2'd3, 8'h30);
    load_ab(2'd0, 2'd3);
    AddrSel = 0; MemRData = 8'h9C; MDRload = 1;
    #1;
    chk("load_addr", MemAddr, 8'h30);
    tick(); clr();
    RegIn = 1; RFWrite = 1; tick(); clr();
    read_rf(2'd0, rd); chk("load_r0", rd, 8'h9C);

    // Read in the same cycle as a write returns the old value.
    write_rf(2'd2, 8'h11);
    load_ab(2'd2, 2'd2);
    MemRData = 8'h77; MDRload = 1; tick(); clr();
    RegIn = 1; RFWrite = 1; ABLD = 1; tick(); clr();
    chk("nobypass_a", Aout, 8'h11);
    chk("wdata_is_a", MemWData, 8'h11);
    ABLD = 1; tick(); clr();
    chk("after_write_a", Aout, 8'h77);

    // Asynchronous reset pulse between edges.
    write_rf(2'd1, 8'h33);
    set_pc(8'h20);
    load_ab(2'd1, 2'd1);
    chk("pre_rst_pc", PCout, 8'h20);
    chk("pre_rst_a", Aout, 8'h33);
    #2;
    reset = 1;
    #1;
    chk("async_pc", PCout, 8'h00);
    chk("async_a", Aout, 8'h00);
    chk("async_b", Bout, 8'h00);
    chk("async_ir", OpCode, 8'h00);
    chk("async_wdata", MemWData, 8'h00);
    #1;
    reset = 0;
    read_rf(2'd1, rd); chk("async_r1", rd, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
